q16_div_seq: RTL and testbench

- Multi-cycle sequential Q16.16 signed divider with valid/ready handshakes on both input and output.
- Inverse companion to the combinational Q16.16 multiply. Used in the ray pipeline for reciprocal and normalisation steps, where a single-cycle divider does not meet area or timing.
- Computes quot = (a · 2^FRAC_BITS) / b. Retires one quotient bit per clock using a restoring algorithm, then applies sign, saturation and divide-by-zero handling.

---
 rtl/q16_div_seq.sv | 89 ++++++++
 tb/tb_q16_div_seq.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/q16_div_seq.sv
// q16_div_seq: multi-cycle restoring Q16.16 signed divider, quot = (a << FRAC_BITS) / b
// Ports: clk/rst_n (async active-low); in_valid/in_ready with operands a, b;
//        out_valid/out_ready with result quot and flags div_by_zero, overflow.
//        One quotient bit per CALC cycle; sign, saturation and zero handling in FIX.
module q16_div_seq #(
  parameter int WIDTH = 32,
  parameter int FRAC_BITS = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quot,
  output logic             div_by_zero,
  output logic             overflow
);
  localparam int N = WIDTH + FRAC_BITS;
  localparam int CW = $clog2(N + 1);
  localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
  state_t state, state_nxt;
  logic sign, a_neg, zero, take, fix_ovf;
  logic [WIDTH-1:0] dvs, a_mag, b_mag, fix_quot;
  logic [N-1:0] dvd, q;
  logic [WIDTH:0] rem;
  logic [WIDTH+1:0] rem_sh;
  logic [CW-1:0] cnt;
  assign in_ready = state == IDLE;
  assign out_valid = state == DONE;
  // Magnitudes as unsigned WIDTH bits; the most negative operand maps to 2^(WIDTH-1).
  assign a_mag = a[WIDTH-1] ? -a : a;
  assign b_mag = b[WIDTH-1] ? -b : b;
  assign rem_sh = {rem, dvd[N-1]};
  assign take = rem_sh >= (WIDTH+2)'(dvs);
  // A negative result may reach magnitude 2^(WIDTH-1); a positive one may not.
  assign fix_ovf = !zero && (sign ? q > N'(MIN_NEG) : q > N'(MAX_POS));
  assign fix_quot = zero ? (a_neg ? MIN_NEG : MAX_POS) :
                    fix_ovf ? (sign ? MIN_NEG : MAX_POS) :
                    sign ? -q[WIDTH-1:0] : q[WIDTH-1:0];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nxt;
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: state_nxt = in_valid ? (b == '0 ? FIX : CALC) : IDLE;
      CALC: state_nxt = cnt == CW'(1) ? FIX : CALC;
      FIX:  state_nxt = DONE;
      DONE: state_nxt = out_ready ? IDLE : DONE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sign <= 1'b0;
      a_neg <= 1'b0;
      zero <= 1'b0;
      dvs <= '0;
      dvd <= '0;
      rem <= '0;
      q <= '0;
      cnt <= '0;
      quot <= '0;
      div_by_zero <= 1'b0;
      overflow <= 1'b0;
    end else if (state == IDLE && in_valid) begin
      sign <= a[WIDTH-1] ^ b[WIDTH-1];
      a_neg <= a[WIDTH-1];
      zero <= b == '0;
      dvs <= b_mag;
      dvd <= {a_mag, {FRAC_BITS{1'b0}}};
      rem <= '0;
      q <= '0;
      cnt <= CW'(N);
    end else if (state == CALC) begin
      dvd <= dvd << 1;
      rem <= take ? (WIDTH+1)'(rem_sh - (WIDTH+2)'(dvs)) : rem_sh[WIDTH:0];
      q <= {q[N-2:0], take};
      cnt <= cnt - 1'b1;
    end else if (state == FIX) begin
      quot <= fix_quot;
      div_by_zero <= zero;
      overflow <= fix_ovf;
    end
endmodule

// File: tb/tb_q16_div_seq.sv
module tb_q16_div_seq;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b1;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic in_ready, out_valid, div_by_zero, overflow;
  logic [31:0] quot;
  int checks = 0;
  int errors = 0;
  logic [31:0] e_quot;
  logic e_dbz, e_ovf;
  int e_lat, lat;
  bit busy, seen;

  q16_div_seq dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .quot(quot), .div_by_zero(div_by_zero), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: exact 64-bit signed division of the scaled dividend, truncating toward zero.
  function automatic void model(input logic [31:0] x, input logic [31:0] y,
                                output logic [31:0] q, output logic dz, output logic ov,
                                output int l);
    longint n, r;
    dz = 1'b0;
    ov = 1'b0;
    q = '0;
    l = 50;
    if (y == 0) begin
      dz = 1'b1;
      l = 2;
      q = x[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
    end else begin
      n = longint'($signed(x)) * 65536;
      r = n / longint'($signed(y));
      if (r > 64'sd2147483647) begin
        ov = 1'b1;
        q = 32'h7FFF_FFFF;
      end else if (r < -64'sd2147483648) begin
        ov = 1'b1;
        q = 32'h8000_0000;
      end else q = r[31:0];
    end
  endfunction

  // Scoreboard: expectation captured at each accepted operand, latency counted from the accept edge as 1.
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      busy <= 1'b0;
      seen <= 1'b0;
      lat <= 0;
    end else if (in_valid && in_ready) begin
      logic [31:0] mq;
      logic md, mo;
      int ml;
      model(a, b, mq, md, mo, ml);
      e_quot <= mq;
      e_dbz <= md;
      e_ovf <= mo;
      e_lat <= ml;
      busy <= 1'b1;
      seen <= 1'b0;
      lat <= 1;
    end else begin
      if (busy) lat <= lat + 1;
      if (out_valid && out_ready) busy <= 1'b0;
    end

  always @(negedge clk)
    if (rst_n && out_valid) begin
      chk("valid_while_busy", 32'(busy), 32'd1);
      chk("in_ready_low_in_done", 32'(in_ready), 32'd0);
      if (busy) begin
        if (!seen) begin
          chk("latency", lat, e_lat);
          seen <= 1'b1;
        end
        chk("model_quot", quot, e_quot);
        chk("model_dbz", 32'(div_by_zero), 32'(e_dbz));
        chk("model_ovf", 32'(overflow), 32'(e_ovf));
      end
    end

  task automatic run(input logic [31:0] x, input logic [31:0] y, input logic [31:0] eq,
                     input logic ed, input logic eo, input int hold);
    int i;
    i = 0;
    @(negedge clk);
    while (!in_ready && i < 100) begin
      @(negedge clk);
      i++;
    end
    chk("in_ready_before_op", 32'(in_ready), 32'd1);
    a = x;
    b = y;
    in_valid = 1'b1;
    out_ready = hold == 0;
    @(negedge clk);
    in_valid = 1'b0;
    i = 0;
    while (!out_valid && i < 100) begin
      @(negedge clk);
      i++;
    end
    chk("out_valid_timeout", 32'(out_valid), 32'd1);
    chk("lit_quot", quot, eq);
    chk("lit_dbz", 32'(div_by_zero), 32'(ed));
    chk("lit_ovf", 32'(overflow), 32'(eo));
    for (int k = 0; k < hold; k++) begin
      a = 32'h0001_0000;
      b = 32'h0001_0000;
      in_valid = 1'b1;
      @(negedge clk);
      chk("hold_valid", 32'(out_valid), 32'd1);
      chk("hold_in_ready", 32'(in_ready), 32'd0);
      chk("hold_quot", quot, eq);
      chk("hold_flags", {30'd0, div_by_zero, overflow}, {30'd0, ed, eo});
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("post_hs_out_valid", 32'(out_valid), 32'd0);
    chk("post_hs_in_ready", 32'(in_ready), 32'd1);
  endtask

  initial begin
    logic [31:0] mq;
    logic md, mo;
    int ml;
    model(32'h0001_0000, 32'h0003_0000, mq, md, mo, ml);
    chk("model_pin_third", mq, 32'h0000_5555);
    model(32'hFFFF_0000, 32'h0003_0000, mq, md, mo, ml);
    chk("model_pin_neg_third", mq, 32'hFFFF_AAAB);
    model(32'h8000_0000, 32'h0000_0001, mq, md, mo, ml);
    chk("model_pin_ovf", {mq[31:1], mo}, {31'h4000_0000, 1'b1});
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_quot", quot, 32'd0);
    chk("rst_flags", {30'd0, div_by_zero, overflow}, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    run(32'h0003_0000, 32'h0002_0000, 32'h0001_8000, 1'b0, 1'b0, 0);
    run(32'hFFFD_0000, 32'h0002_0000, 32'hFFFE_8000, 1'b0, 1'b0, 0);
    run(32'h0001_0000, 32'h0003_0000, 32'h0000_5555, 1'b0, 1'b0, 0);
    run(32'hFFFF_0000, 32'h0003_0000, 32'hFFFF_AAAB, 1'b0, 1'b0, 0);
    run(32'h0005_0000, 32'h0000_0000, 32'h7FFF_FFFF, 1'b1, 1'b0, 0);
    run(32'hFFFB_0000, 32'h0000_0000, 32'h8000_0000, 1'b1, 1'b0, 0);
    run(32'h7FFF_FFFF, 32'h0000_0001, 32'h7FFF_FFFF, 1'b0, 1'b1, 0);
    run(32'h8000_0000, 32'h0000_0001, 32'h8000_0000, 1'b0, 1'b1, 0);
    run(32'h8000_0000, 32'h0001_0000, 32'h8000_0000, 1'b0, 1'b0, 0);
    run(32'h8000_0000, 32'hFFFF_0000, 32'h7FFF_FFFF, 1'b0, 1'b1, 0);
    run(32'h0007_0000, 32'hFFFE_0000, 32'hFFFC_8000, 1'b0, 1'b0, 5);
    @(negedge clk);
    a = 32'h0003_0000;
    b = 32'h0002_0000;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (19) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    chk("midrst_quot", quot, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (60) begin
      @(negedge clk);
      if (out_valid) chk("midrst_ghost_result", 32'(out_valid), 32'd0);
    end
    run(32'h0003_0000, 32'h0002_0000, 32'h0001_8000, 1'b0, 1'b0, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
